l1_threshold_servo: RTL and testbench

- Closed-loop threshold controller, directly downstream of the L1 trigger scaler/loop block.
- After each scaler period, reads every beam's count and compares it with the target rate window. It steps that beam's 18-bit threshold up or down, then streams the thresholds to the beamformer trigger using the thresh/thresh_ce/update protocol.
- Also owns the manual threshold write/readback path.

---
 rtl/l1_servo_pkg.sv | 52 +++++
 rtl/l1_threshold_servo_if.sv | 31 +++
 rtl/l1_servo_calc.sv | 30 +++
 rtl/l1_threshold_servo.sv | 153 +++++++++++++++
 tb/tb_l1_threshold_servo.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l1_servo_pkg.sv
// l1_threshold_servo shared types and servo step arithmetic.
// Imported by the servo top, its calc datapath and the interface.
package l1_servo_pkg;

    localparam int THRESH_W = 18;
    localparam int SCAL_W   = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_WAIT,
        S_CALC,
        S_LOAD,
        S_NEXT,
        S_COMMIT
    } state_t;

    function automatic logic [THRESH_W-1:0] servo_step(
        input logic [SCAL_W-1:0]   count,
        input logic [SCAL_W-1:0]   target,
        input logic [15:0]         delta,
        input logic [THRESH_W-1:0] thresh,
        input logic [THRESH_W-1:0] min,
        input logic [THRESH_W-1:0] max,
        input logic [THRESH_W-1:0] step_s,
        input logic [THRESH_W-1:0] step_l
    );
        logic [32:0] c33, t33, d33, hi, lo, err, d4;
        logic [18:0] stp, th19, res;
        c33  = {1'b0, count};
        t33  = {1'b0, target};
        d33  = {17'd0, delta};
        hi   = t33 + d33;
        lo   = (d33 > t33) ? 33'd0 : t33 - d33;
        err  = (c33 >= t33) ? c33 - t33 : t33 - c33;
        d4   = {15'd0, delta, 2'b00};
        stp  = (err > d4) ? {1'b0, step_l} : {1'b0, step_s};
        th19 = {1'b0, thresh};
        if (c33 > hi)
            res = th19 + stp;
        else if (c33 < lo)
            res = (th19 < stp) ? 19'd0 : th19 - stp;
        else
            res = th19;
        if (res > {1'b0, max})
            res = {1'b0, max};
        if (res < {1'b0, min})
            res = {1'b0, min};
        return res[THRESH_W-1:0];
    endfunction

endpackage

// File: rtl/l1_threshold_servo_if.sv
// Manual threshold access and trigger load bus.
// master = host/trigger side, slave = servo.
interface l1_threshold_servo_if #(
    parameter int NBEAMS = 2
);
    import l1_servo_pkg::*;

    logic [5:0]          thresh_idx_i;
    logic [THRESH_W-1:0] thresh_dat_i;
    logic                thresh_wr_i;
    logic                thresh_upd_i;
    logic                thresh_ack_o;
    logic [THRESH_W-1:0] thresh_dat_o;
    logic [THRESH_W-1:0] thresh_o;
    logic [NBEAMS-1:0]   thresh_ce_o;
    logic                update_o;

    modport master (
        output thresh_idx_i, thresh_dat_i,
        output thresh_wr_i, thresh_upd_i,
        input  thresh_ack_o, thresh_dat_o,
        input  thresh_o, thresh_ce_o, update_o
    );

    modport slave (
        input  thresh_idx_i, thresh_dat_i,
        input  thresh_wr_i, thresh_upd_i,
        output thresh_ack_o, thresh_dat_o,
        output thresh_o, thresh_ce_o, update_o
    );
endinterface

// File: rtl/l1_servo_calc.sv
// Registered CALC datapath: one new threshold per enable.
// Result is valid the cycle after en.
module l1_servo_calc
    import l1_servo_pkg::*;
#(
    parameter logic [THRESH_W-1:0] THRESH_MIN = 18'd0,
    parameter logic [THRESH_W-1:0] THRESH_MAX = 18'h3FFFF,
    parameter logic [THRESH_W-1:0] STEP_SMALL = 18'd1,
    parameter logic [THRESH_W-1:0] STEP_LARGE = 18'd16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [SCAL_W-1:0]   count_i,
    input  logic [SCAL_W-1:0]   target_i,
    input  logic [15:0]         delta_i,
    input  logic [THRESH_W-1:0] thresh_i,
    output logic [THRESH_W-1:0] thresh_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            thresh_o <= '0;
        else if (en)
            thresh_o <= servo_step(count_i, target_i, delta_i,
                                   thresh_i, THRESH_MIN, THRESH_MAX,
                                   STEP_SMALL, STEP_LARGE);
    end

endmodule

// File: rtl/l1_threshold_servo.sv
// Closed-loop L1 trigger threshold servo with manual
// write/readback and trigger update streaming.
module l1_threshold_servo
    import l1_servo_pkg::*;
#(
    parameter int                  NBEAMS      = 2,
    parameter logic [THRESH_W-1:0] THRESH_INIT = 18'd16000,
    parameter logic [THRESH_W-1:0] THRESH_MIN  = 18'd0,
    parameter logic [THRESH_W-1:0] THRESH_MAX  = 18'h3FFFF,
    parameter logic [THRESH_W-1:0] STEP_SMALL  = 18'd1,
    parameter logic [THRESH_W-1:0] STEP_LARGE  = 18'd16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic              servo_enable_i,
    input  logic              count_done_i,
    output logic [5:0]        scal_idx_o,
    input  logic [SCAL_W-1:0] scal_dat_i,
    input  logic [SCAL_W-1:0] target_rate_i,
    input  logic [15:0]       target_delta_i,
    output logic              busy_o,
    output logic              overrun_o,
    l1_threshold_servo_if.slave bus
);

    localparam int BW = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;

    logic [1:0]          rst_sync;
    logic                rst_n;
    state_t              st_q, st_d;
    logic [BW-1:0]       beam_q, beam_d;
    logic                servo_q, servo_d;
    logic                wr_en;
    logic                idx_ok;
    logic [BW-1:0]       idx_b;
    logic [THRESH_W-1:0] thr_q [NBEAMS];
    logic [THRESH_W-1:0] calc_q;

    // Async assert, sync release of the internal reset.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i)
            rst_sync <= 2'b00;
        else
            rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign idx_ok = {26'd0, bus.thresh_idx_i} < 32'(NBEAMS);
    assign idx_b  = bus.thresh_idx_i[BW-1:0];

    l1_servo_calc #(
        .THRESH_MIN (THRESH_MIN),
        .THRESH_MAX (THRESH_MAX),
        .STEP_SMALL (STEP_SMALL),
        .STEP_LARGE (STEP_LARGE)
    ) u_calc (
        .clk      (wb_clk_i),
        .rst_n    (rst_n),
        .en       (st_q == S_CALC),
        .count_i  (scal_dat_i),
        .target_i (target_rate_i),
        .delta_i  (target_delta_i),
        .thresh_i (thr_q[beam_q]),
        .thresh_o (calc_q)
    );

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= S_IDLE;
            beam_q  <= '0;
            servo_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            beam_q  <= beam_d;
            servo_q <= servo_d;
        end
    end

    always_comb begin
        st_d             = st_q;
        beam_d           = beam_q;
        servo_d          = servo_q;
        wr_en            = 1'b0;
        bus.thresh_ack_o = 1'b0;
        unique case (st_q)
            S_IDLE: begin
                if (count_done_i && servo_enable_i) begin
                    st_d    = S_RD_ADDR;
                    beam_d  = '0;
                    servo_d = 1'b1;
                end else if (bus.thresh_upd_i) begin
                    bus.thresh_ack_o = 1'b1;
                    st_d             = S_LOAD;
                    beam_d           = '0;
                    servo_d          = 1'b0;
                end else if (bus.thresh_wr_i) begin
                    bus.thresh_ack_o = 1'b1;
                    wr_en            = idx_ok;
                end
            end
            S_RD_ADDR: st_d = S_RD_WAIT;
            S_RD_WAIT: st_d = S_CALC;
            S_CALC:    st_d = S_LOAD;
            S_LOAD:    st_d = S_NEXT;
            S_NEXT: begin
                if (beam_q == BW'(NBEAMS - 1)) begin
                    st_d = S_COMMIT;
                end else begin
                    beam_d = beam_q + 1'b1;
                    st_d   = servo_q ? S_RD_ADDR : S_LOAD;
                end
            end
            S_COMMIT:  st_d = S_IDLE;
            default:   st_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o          = (st_q != S_IDLE);
        overrun_o       = busy_o && count_done_i && servo_enable_i;
        bus.update_o    = (st_q == S_COMMIT);
        scal_idx_o      = 6'd0;
        bus.thresh_o    = '0;
        bus.thresh_ce_o = '0;
        if (st_q == S_RD_ADDR || st_q == S_RD_WAIT || st_q == S_CALC)
            scal_idx_o = 6'(beam_q);
        // A servo pass loads the freshly computed value.
        if (st_q == S_LOAD) begin
            bus.thresh_o    = servo_q ? calc_q : thr_q[beam_q];
            bus.thresh_ce_o = NBEAMS'(1) << beam_q;
        end
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NBEAMS; i++)
                thr_q[i] <= THRESH_INIT;
        end else begin
            if (wr_en)
                thr_q[idx_b] <= bus.thresh_dat_i;
            if (st_q == S_LOAD && servo_q)
                thr_q[beam_q] <= calc_q;
        end
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n)
            bus.thresh_dat_o <= '0;
        else
            bus.thresh_dat_o <= idx_ok ? thr_q[idx_b] : '0;
    end

endmodule

// File: tb/tb_l1_threshold_servo.sv
// Scoreboard bench for l1_threshold_servo with a
// plain-arithmetic reference model of the servo rules.
module tb_l1_threshold_servo;

    localparam int N = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        cd = 1'b0;
    logic [5:0]  scal_idx;
    logic [31:0] scal_dat;
    logic [31:0] target = 32'd0;
    logic [15:0] delta = 16'd0;
    logic        busy, overrun;
    logic [31:0] counts [N];

    l1_threshold_servo_if #(.NBEAMS(N)) bus ();

    l1_threshold_servo #(.NBEAMS(N)) dut (
        .wb_clk_i       (clk),
        .wb_rst_n_i     (rst_n),
        .servo_enable_i (en),
        .count_done_i   (cd),
        .scal_idx_o     (scal_idx),
        .scal_dat_i     (scal_dat),
        .target_rate_i  (target),
        .target_delta_i (delta),
        .busy_o         (busy),
        .overrun_o      (overrun),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    assign scal_dat = (scal_idx < 6'(N)) ? counts[scal_idx[0]] : 32'd0;

    typedef struct {
        bit          upd;
        logic [1:0]  ce;
        logic [17:0] val;
    } ev_t;

    ev_t    exp_q [$];
    int     tests = 0;
    int     fails = 0;
    int     thr [N];
    time    upd_time = 0;
    time    ack_time = 0;

    task automatic check(input string nm, input longint act,
                         input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int ref_step(longint c, longint t,
                                    longint d, longint th);
        longint hi, lo, err, st, r;
        hi  = t + d;
        lo  = (d > t) ? 0 : t - d;
        err = (c > t) ? c - t : t - c;
        st  = (err > 4 * d) ? 16 : 1;
        r   = th;
        if (c > hi)
            r = th + st;
        else if (c < lo)
            r = th - st;
        if (r > 262143) r = 262143;
        if (r < 0) r = 0;
        return int'(r);
    endfunction

    // Scoreboard monitor: every trigger strobe pops one entry.
    always @(negedge clk) begin
        if (rst_n && (bus.thresh_ce_o != '0 || bus.update_o)) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: got ce=%0d upd=%0d expected none",
                         bus.thresh_ce_o, bus.update_o);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (e.upd) begin
                    check("update_o", bus.update_o, 1);
                    check("ce_at_update", bus.thresh_ce_o, 0);
                end else begin
                    check("thresh_ce_o", bus.thresh_ce_o, e.ce);
                    check("thresh_o", bus.thresh_o, e.val);
                end
            end
            if (bus.update_o) upd_time = $time;
        end
    end

    task automatic push_all();
        ev_t e;
        for (int b = 0; b < N; b++) begin
            e.upd = 0;
            e.ce  = 2'(1 << b);
            e.val = 18'(thr[b]);
            exp_q.push_back(e);
        end
        e.upd = 1; e.ce = 0; e.val = 0;
        exp_q.push_back(e);
    endtask

    task automatic start_pass();
        for (int b = 0; b < N; b++)
            thr[b] = ref_step(counts[b], target, delta, thr[b]);
        push_all();
        @(posedge clk); #1 cd = 1'b1;
        @(posedge clk); #1 cd = 1'b0;
    endtask

    task automatic wait_update(output int n);
        n = 1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.update_o) return;
            @(posedge clk); #1;
            n++;
        end
        check("update_timeout", 0, 1);
        n = -1;
    endtask

    task automatic do_write(input int idx, input int dat);
        bit got;
        got = 0;
        @(posedge clk); #1;
        bus.thresh_idx_i = 6'(idx);
        bus.thresh_dat_i = 18'(dat);
        bus.thresh_wr_i  = 1'b1;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (bus.thresh_ack_o) begin
                got = 1;
                ack_time = $time;
            end
        end
        @(posedge clk); #1 bus.thresh_wr_i = 1'b0;
        check("wr_ack", got, 1);
        if (idx < N) thr[idx] = dat;
    endtask

    task automatic do_upd(input bit chk_lat);
        bit got;
        int n;
        got = 0;
        push_all();
        @(posedge clk); #1 bus.thresh_upd_i = 1'b1;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (bus.thresh_ack_o) got = 1;
        end
        @(posedge clk); #1 bus.thresh_upd_i = 1'b0;
        check("upd_ack", got, 1);
        wait_update(n);
        if (chk_lat) check("upd_latency", n, 2 * N + 1);
    endtask

    task automatic readback(input int idx);
        @(posedge clk); #1 bus.thresh_idx_i = 6'(idx);
        @(posedge clk);
        @(negedge clk);
        check($sformatf("readback%0d", idx), bus.thresh_dat_o,
              (idx < N) ? thr[idx] : 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        for (int b = 0; b < N; b++) thr[b] = 16000;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        time t0;
        int seen;
        bus.thresh_idx_i = '0;
        bus.thresh_dat_i = '0;
        bus.thresh_wr_i  = 1'b0;
        bus.thresh_upd_i = 1'b0;
        counts[0] = 0;
        counts[1] = 0;
        do_reset();

        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ce", bus.thresh_ce_o, 0);
        check("rst_update", bus.update_o, 0);
        check("rst_ack", bus.thresh_ack_o, 0);
        check("rst_overrun", overrun, 0);
        check("rst_scal_idx", scal_idx, 0);
        check("rst_thresh_o", bus.thresh_o, 0);
        readback(0);
        readback(1);
        readback(5);

        en = 1'b1;
        target = 1000; delta = 50;
        counts[0] = 1100; counts[1] = 900;
        start_pass();
        wait_update(n);
        check("servo_latency", n, 5 * N + 1);
        readback(0);
        readback(1);
        check("thr0_16001", thr[0], 16001);
        check("thr1_15999", thr[1], 15999);

        delta = 10; counts[0] = 2000; counts[1] = 1000;
        start_pass(); wait_update(n);
        delta = 2000; counts[0] = 0; counts[1] = 0;
        start_pass(); wait_update(n);
        readback(0);
        readback(1);

        do_write(0, 18'h3FFF5);
        do_write(1, 3);
        target = 1000; delta = 10;
        counts[0] = 2000; counts[1] = 0;
        start_pass(); wait_update(n);
        readback(0);
        readback(1);
        check("sat_hi", thr[0], 18'h3FFFF);
        check("sat_lo", thr[1], 0);

        counts[0] = 1000; counts[1] = 1000;
        t0 = $time;
        start_pass();
        do_write(1, 777);
        check("wr_after_update", (ack_time > upd_time) && (upd_time > t0), 1);
        readback(1);
        do_upd(1);

        start_pass();
        repeat (2) @(posedge clk);
        #1 cd = 1'b1;
        @(negedge clk);
        check("overrun_pulse", overrun, 1);
        @(posedge clk); #1 cd = 1'b0;
        @(negedge clk);
        check("overrun_clear", overrun, 0);
        wait_update(n);
        repeat (20) @(posedge clk);
        #1;
        check("no_second_pass", exp_q.size(), 0);

        en = 1'b0;
        @(posedge clk); #1 cd = 1'b1;
        @(negedge clk);
        check("no_overrun_dis", overrun, 0);
        @(posedge clk); #1 cd = 1'b0;
        @(negedge clk);
        check("dis_idle", busy, 0);
        en = 1'b1;

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    target = $urandom_range(0, 5000);
                    delta  = 16'($urandom_range(0, 400));
                    for (int b = 0; b < N; b++) begin
                        if ($urandom_range(0, 5) == 0)
                            counts[b] = $urandom;
                        else
                            counts[b] = 32'($urandom_range(0, 7000));
                    end
                    start_pass(); wait_update(n);
                end
                1: begin
                    if ($urandom_range(0, 1) == 0)
                        do_write($urandom_range(0, 3),
                                 $urandom_range(0, 20));
                    else
                        do_write($urandom_range(0, 3),
                                 262143 - $urandom_range(0, 20));
                end
                2: do_upd(0);
                default: readback($urandom_range(0, 3));
            endcase
        end
        readback(0);
        readback(1);

        start_pass();
        repeat (6) @(posedge clk);
        #1;
        do_reset();
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.update_o) seen++;
        end
        check("no_update_after_rst", seen, 0);
        check("rst_busy2", busy, 0);
        readback(0);
        readback(1);

        repeat (5) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
